// File: rtl/shift_sequencer_if.sv
// Command channel between a requester and shift_sequencer.
//   cmd_valid : requester has a command on cmd_op/cmd_count/cmd_data
//   cmd_ready : sequencer can take the command this cycle
//   cmd_op    : 0 load, 1 hold, 2 shl, 3 shr, 4 rotr, 5 rotl, 6/7 clear
//   cmd_count : repeat count for ops 1-5
//   cmd_data  : parallel-load value for op 0
interface shift_sequencer_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [7:0]       cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/shift_sequencer.sv
// Command sequencer for an 8-bit universal shift register. Commands are
// queued in a small FIFO and each one is played out as an option code held
// on opt_out for N clocks, with one hold cycle between commands.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   cmd        : command channel (slave side), cmd_ready is combinational
//   abort      : flush the queue and stop the running command
//   opt_out    : option code to the register (registered)
//   load_out   : parallel-load data to the register (registered)
//   busy       : a command is executing
//   done       : one-cycle pulse after a command's last execute cycle
//   level      : queue occupancy
module shift_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  shift_sequencer_if.slave        cmd,
  input  logic                    abort,
  output logic [2:0]              opt_out,
  output logic [7:0]              load_out,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam logic [2:0]  OP_HOLD = 3'd1;

  typedef struct packed {
    logic [2:0]       op;
    logic [CNT_W-1:0] count;
    logic [7:0]       data;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_c;
  logic             pop_c;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [2:0]       opt_d;
  logic [7:0]       load_d;
  logic             done_d;

  // Effective cycle count: shifts/rotates/hold repeat, count 0 runs once.
  function automatic logic [CNT_W-1:0] eff_count(input entry_t e);
    if ((e.op >= 3'd1) && (e.op <= 3'd5) && (e.count != '0)) begin
      return e.count;
    end
    return CNT_W'(1);
  endfunction

  assign cmd.cmd_ready = (level < LVL_W'(DEPTH)) && !abort;
  assign push_c        = cmd.cmd_valid && cmd.cmd_ready;
  assign pop_c         = (state_q == IDLE) && (level != '0) && !abort;
  assign head          = mem[rd_ptr];
  assign busy          = (state_q == EXEC);

  always_comb begin
    wr_entry       = '0;
    wr_entry.op    = cmd.cmd_op;
    wr_entry.count = cmd.cmd_count;
    wr_entry.data  = cmd.cmd_data;
  end

  // Queue storage; abort/reset only touch pointers and level.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        level <= level + LVL_W'(1);
      end else if (pop_c && !push_c) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      opt_out  <= OP_HOLD;
      load_out <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      opt_out  <= opt_d;
      load_out <= load_d;
      done     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop_c) state_d = EXEC;
      EXEC: if (rem_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // Next values of the registered outputs and repeat counter.
  always_comb begin
    opt_d  = opt_out;
    load_d = load_out;
    done_d = 1'b0;
    rem_d  = rem_q;
    unique case (state_q)
      IDLE: begin
        opt_d = OP_HOLD;
        if (pop_c) begin
          opt_d  = head.op;
          load_d = head.data;
          rem_d  = eff_count(head);
        end
      end
      EXEC: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          opt_d  = OP_HOLD;
          done_d = 1'b1;
        end
      end
      default: opt_d = OP_HOLD;
    endcase
    if (abort) begin
      opt_d  = OP_HOLD;
      done_d = 1'b0;
    end
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the 8-bit universal shift register. It sits between a requester and the register.
- Commands are accepted on a valid/ready interface and buffered in a small FIFO.
- Each command is executed as an opcode held on the register's 3-bit option bus for N consecutive clocks. It also drives the register's parallel-load data.
- When no command is executing, the register is held.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
CNT_W, 4, width of per-command repeat count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (not full and not abort)
cmd_op  input  3  0 load, 1 hold, 2 shl, 3 shr, 4 rotr, 5 rotl, 6/7 clear
cmd_count  input  CNT_W  repeat count for ops 1-5
cmd_data  input  8  parallel-load value, used by op 0 only
abort  input  1  flush FIFO and stop current command
opt_out  output  3  option code to register (registered)
load_out  output  8  load data to register (registered)
busy  output  1  FSM in EXEC
done  output  1  one-cycle pulse after a command's last EXEC cycle
level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, checked first each edge: FIFO empty, FSM IDLE, opt_out=3'd1 (hold), load_out=0, busy=0, done=0, level=0.
- Reset mid-command: the command is discarded and no done pulse is issued.
- Handshake: a command is written at an edge where cmd_valid&&cmd_ready.
  - cmd_ready = (level<DEPTH) && !abort; it is combinational and independent of cmd_valid.
  - The requester must hold command fields stable while valid && !ready.
- Effective cycle count N:
  - ops 0, 6, 7: N=1, count ignored.
  - ops 1-5: N=max(cmd_count,1), so count 0 executes once.
- FSM has two states.
  - IDLE:
    - opt_out=1, busy=0.
    - If the FIFO is non-empty: pop the head, latch op/data, load remaining=N, go to EXEC.
    - opt_out=op and load_out=data are registered at that same edge.
  - EXEC:
    - busy=1; opt_out and load_out are held constant.
    - remaining decrements each edge.
    - At the edge where remaining==1: go to IDLE, opt_out=1, done=1 for the next cycle.
- Latency with an empty FIFO in IDLE and acceptance at edge 0:
  - opt_out=op from edge 1 to edge 1+N.
  - The register applies the op at edges 2..N+1.
  - done is high between edges N+1 and N+2.
- Back-to-back commands: there is always exactly one IDLE (hold) cycle between consecutive commands.
- Simultaneous push and pop at the same edge: level is unchanged. A push at level==DEPTH cannot happen because ready is low.
- FIFO write/read pointers wrap modulo DEPTH; level is tracked with one extra bit.
- abort, sampled at an edge and taking priority over everything except reset:
  - FIFO flushed (level=0), FSM to IDLE, opt_out=1.
  - done=0 and no done pulse for the aborted command.
  - A cmd_valid in the same cycle is not accepted.
- Abort while IDLE and empty has no effect other than holding cmd_ready low.
- load_out retains its last value in IDLE. It is meaningful to the register only when opt_out==0.
- done and busy are never high in the same cycle.

Test Plan:
- Reset then idle 5 cycles -> opt_out=1, busy=0, done=0, level=0, cmd_ready=1 throughout.
- Push {op0, data 8'hA5} at edge 0 -> opt_out=0 and load_out=A5 for exactly 1 cycle starting at edge 1; done at edge 2; register model Q=A5.
- Push {rotl, count 3} after loading 8'h81 -> opt_out=5 for 3 cycles; Q=0C; done once; busy high 3 cycles.
- Push 5 commands with DEPTH=4 while the first is executing (count 15) -> cmd_ready low once level=4; the stalled 5th is accepted after the first pop; commands execute in order with one hold cycle between them.
- Count 0 with shr on Q=8'h80 -> executes once, Q=40.
- Abort during the 2nd cycle of {shl, count 8} with 2 entries queued -> next cycle opt_out=1, level=0, no done; the following cycle cmd_ready=1.
- Reset asserted mid-EXEC -> next cycle all outputs at reset values; no done pulse.
